acorn128_ctrl: RTL and testbench

Phase sequencer for the ACORN-128 bit-serial core. It drives the control bits (`ca_out`, `cb_out`), the message bit and the step enable for the 293-bit state register, and the state register feeds `fbk128` and `ksg128`. It also accepts associated data and plaintext as 1-bit valid/ready streams, emits ciphertext bits, and collects the 128-bit tag from `ksg128`'s keystream.

---
 rtl/acorn128_pkg.sv | 10 +
 rtl/acorn128_ctrl.sv | 95 +++++++++
 tb/tb_acorn128_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/acorn128_pkg.sv
// acorn128_pkg: phase encoding and step budgets for the ACORN-128 sequencer
package acorn128_pkg;
  typedef enum logic [3:0] {IDLE, LOAD, INIT, AD, AD_PAD, ENC, ENC_PAD, FIN, DONE} phase_e;
  localparam int INIT_STEPS = 1792;
  localparam int PAD_STEPS = 256;
  localparam int PAD_CA_STEPS = 128;
  localparam int FIN_STEPS = 768;
  localparam int TAG_BITS = 128;
  localparam int TAG_START = 640;
endpackage

// File: rtl/acorn128_ctrl.sv
// acorn128_ctrl: phase sequencer driving the ACORN-128 bit-serial state register
module acorn128_ctrl
  import acorn128_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_in,
  input  logic [127:0]        key_in,
  input  logic [127:0]        iv_in,
  input  logic [LEN_W-1:0]    ad_len_in,
  input  logic [LEN_W-1:0]    pt_len_in,
  input  logic                ad_bit_in,
  input  logic                ad_valid_in,
  output logic                ad_ready_out,
  input  logic                pt_bit_in,
  input  logic                pt_valid_in,
  output logic                pt_ready_out,
  input  logic                ks_in,
  output logic                clr_state_out,
  output logic                step_en_out,
  output logic                m_out,
  output logic                ca_out,
  output logic                cb_out,
  output logic                ct_bit_out,
  output logic                ct_valid_out,
  output logic                busy_out,
  output logic                done_out,
  output logic [TAG_BITS-1:0] tag_out
);
  phase_e state, state_nx;
  logic [10:0] cnt;
  logic [127:0] key, iv;
  logic [LEN_W-1:0] ad_rem, pt_rem;
  logic [TAG_BITS-1:0] tag;
  logic [6:0] tag_idx;
  logic init_m, pad;
  assign tag_idx = 7'(cnt - 11'(TAG_START));
  assign pad = state inside {AD_PAD, ENC_PAD};
  assign init_m = (cnt[10:7] == 4'd1) ? iv[cnt[6:0]] : key[cnt[6:0]] ^ (cnt == 11'd256);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start_in ? LOAD : IDLE;
      LOAD:    state_nx = INIT;
      INIT:    state_nx = (cnt == 11'(INIT_STEPS - 1)) ? ((ad_rem == '0) ? AD_PAD : AD) : INIT;
      AD:      state_nx = (ad_valid_in && ad_rem == LEN_W'(1)) ? AD_PAD : AD;
      AD_PAD:  state_nx = (cnt == 11'(PAD_STEPS - 1)) ? ((pt_rem == '0) ? ENC_PAD : ENC) : AD_PAD;
      ENC:     state_nx = (pt_valid_in && pt_rem == LEN_W'(1)) ? ENC_PAD : ENC;
      ENC_PAD: state_nx = (cnt == 11'(PAD_STEPS - 1)) ? FIN : ENC_PAD;
      FIN:     state_nx = (cnt == 11'(FIN_STEPS - 1)) ? DONE : FIN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign step_en_out = (state inside {INIT, AD_PAD, ENC_PAD, FIN}) | (state == AD & ad_valid_in) |
                       (state == ENC & pt_valid_in);
  assign m_out = (state == INIT) ? init_m : (state == AD) ? ad_bit_in : (state == ENC) ? pt_bit_in :
                 pad & (cnt == '0);
  assign ca_out = (state inside {INIT, AD, ENC, FIN}) | (pad & (cnt < 11'(PAD_CA_STEPS)));
  assign cb_out = state inside {INIT, AD, AD_PAD, FIN};
  assign clr_state_out = state == LOAD;
  assign ad_ready_out = state == AD;
  assign pt_ready_out = state == ENC;
  assign ct_valid_out = pt_ready_out & pt_valid_in;
  assign ct_bit_out = pt_ready_out & (pt_bit_in ^ ks_in);
  assign busy_out = !(state inside {IDLE, DONE});
  assign done_out = state == DONE;
  assign tag_out = tag;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      key <= '0;
      iv <= '0;
      ad_rem <= '0;
      pt_rem <= '0;
      tag <= '0;
    end else begin
      state <= state_nx;
      cnt <= (state_nx != state) ? '0 : cnt + 11'(step_en_out);
      if (state == IDLE && start_in) begin
        key <= key_in;
        iv <= iv_in;
        ad_rem <= ad_len_in;
        pt_rem <= pt_len_in;
        tag <= '0;
      end
      if (state == AD && ad_valid_in) ad_rem <= ad_rem - LEN_W'(1);
      if (state == ENC && pt_valid_in) pt_rem <= pt_rem - LEN_W'(1);
      if (state == FIN && cnt >= 11'(TAG_START)) tag[tag_idx] <= ks_in;
    end
  end
endmodule

// File: tb/tb_acorn128_ctrl.sv
// tb_acorn128_ctrl: randomized jobs checked against a per-step expectation queue
module tb_acorn128_ctrl;
  localparam int LEN_W = 16;
  localparam int P_INIT = 0, P_AD = 1, P_ADP = 2, P_ENC = 3, P_ENCP = 4, P_FIN = 5, P_LOAD = 6;
  typedef struct {int ph; bit m; bit ca; bit cb; int idx;} ent_t;
  logic clk = 0, rst = 1, start_in = 0;
  logic [127:0] key_in = '0, iv_in = '0;
  logic [LEN_W-1:0] ad_len_in = '0, pt_len_in = '0;
  logic ad_bit_in = 0, ad_valid_in = 0, pt_bit_in = 0, pt_valid_in = 0, ks_in = 0;
  logic ad_ready_out, pt_ready_out, clr_state_out, step_en_out, m_out, ca_out, cb_out;
  logic ct_bit_out, ct_valid_out, busy_out, done_out;
  logic [127:0] tag_out;
  int n_vec = 0, n_err = 0;
  int done_cyc, steps, ad_rdy, stalls;
  always #5 clk = ~clk;
  acorn128_ctrl #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .key_in(key_in), .iv_in(iv_in),
    .ad_len_in(ad_len_in), .pt_len_in(pt_len_in), .ad_bit_in(ad_bit_in), .ad_valid_in(ad_valid_in),
    .ad_ready_out(ad_ready_out), .pt_bit_in(pt_bit_in), .pt_valid_in(pt_valid_in),
    .pt_ready_out(pt_ready_out), .ks_in(ks_in), .clr_state_out(clr_state_out),
    .step_en_out(step_en_out), .m_out(m_out), .ca_out(ca_out), .cb_out(cb_out),
    .ct_bit_out(ct_bit_out), .ct_valid_out(ct_valid_out), .busy_out(busy_out),
    .done_out(done_out), .tag_out(tag_out)
  );
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic run_job(input logic [127:0] k, input logic [127:0] v, input int al, input int pl,
                         input int am, input int pm, input bit fin_start, input int abort_at);
    ent_t q[$];
    ent_t f;
    bit adb[$], ptb[$];
    logic [127:0] et;
    logic [4:0] ctl_e;
    logic [3:0] hs_e;
    logic [1:0] st_e;
    bit adv, ptv, ks, es;
    int c, post, acyc, pcyc;
    done_cyc = -1; steps = 0; ad_rdy = 0; stalls = 0;
    et = '0; post = 0; acyc = 0; pcyc = 0;
    for (int j = 0; j < al; j++) adb.push_back(1'($urandom));
    for (int j = 0; j < pl; j++) ptb.push_back(1'($urandom));
    q.push_back('{P_LOAD, 1'b0, 1'b0, 1'b0, 0});
    for (int i = 0; i < 1792; i++)
      q.push_back('{P_INIT, (i < 128) ? k[i] : (i < 256) ? v[i-128] : (i == 256) ? ~k[0] : k[i%128], 1'b1, 1'b1, i});
    foreach (adb[j]) q.push_back('{P_AD, adb[j], 1'b1, 1'b1, j});
    for (int i = 0; i < 256; i++) q.push_back('{P_ADP, i == 0, i < 128, 1'b1, i});
    foreach (ptb[j]) q.push_back('{P_ENC, ptb[j], 1'b1, 1'b0, j});
    for (int i = 0; i < 256; i++) q.push_back('{P_ENCP, i == 0, i < 128, 1'b0, i});
    for (int i = 0; i < 768; i++) q.push_back('{P_FIN, 1'b0, 1'b1, 1'b1, i});
    @(posedge clk); #1;
    start_in = 1; key_in = k; iv_in = v; ad_len_in = LEN_W'(al); pt_len_in = LEN_W'(pl);
    @(posedge clk); #1;
    start_in = 0;
    c = 1;
    forever begin
      if (q.size() == 0) post++;
      f = (q.size() != 0) ? q[0] : '{-1, 1'b0, 1'b0, 1'b0, 0};
      key_in = rand128(); iv_in = rand128();
      ad_len_in = LEN_W'($urandom); pt_len_in = LEN_W'($urandom);
      adv = (f.ph == P_AD) ? ((am == 0) ? 1'b1 : (am == 1) ? acyc[0] : 1'($urandom)) : 1'($urandom);
      ptv = (f.ph == P_ENC) ? ((pm == 0) ? 1'b1 : (pm == 1) ? pcyc[0] : 1'($urandom)) : 1'($urandom);
      ad_valid_in = adv; ad_bit_in = (f.ph == P_AD) ? f.m : 1'($urandom);
      pt_valid_in = ptv; pt_bit_in = (f.ph == P_ENC) ? f.m : 1'($urandom);
      ks = 1'($urandom); ks_in = ks;
      start_in = fin_start && f.ph == P_FIN && (f.idx inside {[100:103]});
      if (c == abort_at) rst = 1;
      #1;
      es = (f.ph inside {P_INIT, P_ADP, P_ENCP, P_FIN}) || (f.ph == P_AD && adv) || (f.ph == P_ENC && ptv);
      ctl_e = {f.ph == P_LOAD, es, f.m, f.ca, f.cb};
      hs_e = {f.ph == P_AD, f.ph == P_ENC, f.ph == P_ENC && ptv, f.ph == P_ENC && ptv && (f.m ^ ks)};
      st_e = {post == 0, post == 1};
      n_vec++;
      if ({clr_state_out, step_en_out, m_out, ca_out, cb_out} !== ctl_e) begin
        n_err++;
        $display("FAIL ctl c=%0d ph=%0d idx=%0d got clr/step/m/ca/cb=%b exp=%b", c, f.ph, f.idx,
                 {clr_state_out, step_en_out, m_out, ca_out, cb_out}, ctl_e);
      end
      n_vec++;
      if ({ad_ready_out, pt_ready_out, ct_valid_out, ct_bit_out & (f.ph == P_ENC && ptv)} !== hs_e) begin
        n_err++;
        $display("FAIL stream c=%0d ph=%0d got adr/ptr/ctv/ct=%b exp=%b", c, f.ph,
                 {ad_ready_out, pt_ready_out, ct_valid_out, ct_bit_out}, hs_e);
      end
      n_vec++;
      if ({busy_out, done_out} !== st_e) begin
        n_err++;
        $display("FAIL status c=%0d got busy/done=%b exp=%b", c, {busy_out, done_out}, st_e);
      end
      if (c == 1) begin
        n_vec++;
        if (tag_out !== '0) begin n_err++; $display("FAIL tag_clear got=%h exp=0", tag_out); end
      end
      if (post >= 1) begin
        n_vec++;
        if (tag_out !== et) begin n_err++; $display("FAIL tag c=%0d got=%h exp=%h", c, tag_out, et); end
      end
      if (done_out === 1'b1 && done_cyc < 0) done_cyc = c;
      if (step_en_out === 1'b1) steps++;
      if (ad_ready_out === 1'b1) ad_rdy++;
      if ((f.ph == P_AD && !adv) || (f.ph == P_ENC && !ptv)) stalls++;
      if (f.ph == P_FIN && f.idx >= 640) et[f.idx-640] = ks;
      if (f.ph == P_AD) acyc++;
      if (f.ph == P_ENC) pcyc++;
      if (es || f.ph == P_LOAD) void'(q.pop_front());
      if (c == abort_at) begin
        @(posedge clk); #1;
        rst = 0; start_in = 0; pt_bit_in = 0; ks_in = 0;
        #1;
        n_vec++;
        if ({clr_state_out, step_en_out, m_out, ca_out, cb_out, ad_ready_out, pt_ready_out,
             ct_valid_out, ct_bit_out, busy_out, done_out} !== 11'b0 || tag_out !== '0) begin
          n_err++;
          $display("FAIL abort got outs=%b tag=%h exp all 0", {clr_state_out, step_en_out, m_out, ca_out,
                   cb_out, ad_ready_out, pt_ready_out, ct_valid_out, ct_bit_out, busy_out, done_out}, tag_out);
        end
        break;
      end
      if (post == 2) break;
      if (c >= 20000) begin
        n_err++;
        $display("FAIL timeout c=%0d got no done exp done", c);
        break;
      end
      @(posedge clk); #1;
      c++;
    end
    start_in = 0; ad_valid_in = 0; pt_valid_in = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start_in = 1'($urandom); ad_valid_in = 1'($urandom); pt_valid_in = 1'($urandom);
      ad_bit_in = 1'($urandom);
      #1;
      n_vec++;
      if ({clr_state_out, step_en_out, m_out, ca_out, cb_out, ad_ready_out, pt_ready_out,
           ct_valid_out, ct_bit_out, busy_out, done_out} !== 11'b0 || tag_out !== '0) begin
        n_err++;
        $display("FAIL reset got outs=%b tag=%h exp all 0", {clr_state_out, step_en_out, m_out, ca_out,
                 cb_out, ad_ready_out, pt_ready_out, ct_valid_out, ct_bit_out, busy_out, done_out}, tag_out);
      end
    end
    @(posedge clk); #1;
    rst = 0; start_in = 0; ad_valid_in = 0; pt_valid_in = 0;
  endtask
  task automatic test_zero_len();
    run_job('0, '0, 0, 0, 0, 0, 1'b0, 0);
    n_vec++;
    if (done_cyc !== 3074) begin n_err++; $display("FAIL zero_done got=%0d exp=3074", done_cyc); end
    n_vec++;
    if (steps !== 3072) begin n_err++; $display("FAIL zero_steps got=%0d exp=3072", steps); end
  endtask
  task automatic test_key_one();
    run_job(128'h1, rand128(), 0, 0, 0, 0, 1'b0, 0);
    n_vec++;
    if (done_cyc !== 3074) begin n_err++; $display("FAIL key1_done got=%0d exp=3074", done_cyc); end
  endtask
  task automatic test_ad_pt();
    run_job(rand128(), rand128(), 8, 8, 0, 0, 1'b0, 0);
    n_vec++;
    if (done_cyc !== 3090) begin n_err++; $display("FAIL adpt_done got=%0d exp=3090", done_cyc); end
    n_vec++;
    if (ad_rdy !== 8) begin n_err++; $display("FAIL adpt_ready got=%0d exp=8", ad_rdy); end
  endtask
  task automatic test_ad_stall();
    run_job(rand128(), rand128(), 4, 0, 1, 0, 1'b0, 0);
    n_vec++;
    if (done_cyc !== 3082) begin n_err++; $display("FAIL stall_done got=%0d exp=3082", done_cyc); end
    n_vec++;
    if (ad_rdy !== 8) begin n_err++; $display("FAIL stall_ready got=%0d exp=8", ad_rdy); end
  endtask
  task automatic test_abort();
    run_job(rand128(), rand128(), 5, 5, 0, 0, 1'b0, 502);
    run_job(rand128(), rand128(), 3, 2, 2, 2, 1'b0, 0);
    n_vec++;
    if (done_cyc !== 3074 + 5 + stalls) begin
      n_err++; $display("FAIL restart_done got=%0d exp=%0d", done_cyc, 3074 + 5 + stalls);
    end
  endtask
  task automatic test_start_in_fin();
    run_job(rand128(), rand128(), 0, 3, 0, 0, 1'b1, 0);
    n_vec++;
    if (done_cyc !== 3077) begin n_err++; $display("FAIL finstart_done got=%0d exp=3077", done_cyc); end
  endtask
  task automatic test_random();
    int al, pl;
    for (int n = 0; n < 5; n++) begin
      al = $urandom_range(0, 24);
      pl = $urandom_range(0, 24);
      run_job(rand128(), rand128(), al, pl, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 0);
      n_vec++;
      if (done_cyc !== 3074 + al + pl + stalls) begin
        n_err++; $display("FAIL rand_done n=%0d got=%0d exp=%0d", n, done_cyc, 3074 + al + pl + stalls);
      end
    end
  endtask
  initial begin
    test_reset();
    test_zero_len();
    test_key_one();
    test_ad_pt();
    test_ad_stall();
    test_abort();
    test_start_in_fin();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
